rf_wb_scheduler: RTL and testbench

- Sequences all writes into the 32x32 integer register file.
- Round-robin arbitrates the single write port between NUM_REQ writeback sources (ALU, LSU, AES unit).
- Keeps a pending-destination scoreboard so the issue stage stalls on RAW/WAW hazards until the producing write has landed.
- Sits between the execute units and the register file. Drives its reg_write/rd_addr/rd_data inputs and shares its start enable.

---
 rtl/rv_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/rf_wb_scheduler.sv | 96 +++++++++
 tb/tb_rf_wb_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared integer-core constants used by the writeback scheduler.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int RA_W     = 5;
    localparam int NUM_REGS = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_AES = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over N requesters; the pointer advances past each winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] idx;
    logic          found;
    int            j;

    // Scan from ptr upward, wrapping modulo N; first requester wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        if (start) begin
            for (int k = 0; k < N; k++) begin
                j = int'(ptr) + k;
                if (j >= N) j = j - N;
                idx = PW'(j);
                if (!found && req[idx]) begin
                    grant[idx] = 1'b1;
                    gidx       = idx;
                    found      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback port arbiter, write register stage and RAW/WAW scoreboard.
module rf_wb_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int RA_W    = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    iss_valid,
    input  logic [RA_W-1:0]         iss_rs1,
    input  logic [RA_W-1:0]         iss_rs2,
    input  logic [RA_W-1:0]         iss_rd,
    input  logic                    iss_has_rd,
    output logic                    iss_ready,
    input  logic [NUM_REQ-1:0]      wb_valid,
    input  logic [NUM_REQ*RA_W-1:0] wb_rd,
    input  logic [NUM_REQ*XLEN-1:0] wb_data,
    output logic [NUM_REQ-1:0]      wb_ready,
    output logic                    rf_we,
    output logic [RA_W-1:0]         rf_rd_addr,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [31:0]             pending,
    output logic                    err_unexp_wb
);

    import rv_pkg::*;

    logic [NUM_REQ-1:0]  grant;
    logic                xfer;
    logic [RA_W-1:0]     sel_rd;
    logic [XLEN-1:0]     sel_data;
    logic                stall;
    logic                set_en;
    logic                clr_en;
    logic [NUM_REGS-1:0] pend_q;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .req   (wb_valid),
        .grant (grant)
    );

    assign wb_ready = grant;
    assign xfer     = |grant;
    assign pending  = pend_q;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = wb_rd[i*RA_W +: RA_W];
                sel_data = wb_data[i*XLEN +: XLEN];
            end
        end
    end

    assign stall = (iss_rs1 != '0 && pend_q[iss_rs1])
                || (iss_rs2 != '0 && pend_q[iss_rs2])
                || (iss_has_rd && iss_rd != '0 && pend_q[iss_rd]);

    assign iss_ready = start && !stall;
    assign set_en    = iss_valid && iss_ready && iss_has_rd && iss_rd != '0;
    // Release coincides with the register file commit edge.
    assign clr_en    = start && rf_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_wdata   <= '0;
        end else if (start) begin
            rf_we <= xfer && sel_rd != '0;
            if (xfer) begin
                rf_rd_addr <= sel_rd;
                rf_wdata   <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q       <= '0;
            err_unexp_wb <= 1'b0;
        end else begin
            if (set_en) pend_q[iss_rd] <= 1'b1;
            if (clr_en) pend_q[rf_rd_addr] <= 1'b0;
            if (clr_en && !pend_q[rf_rd_addr]) err_unexp_wb <= 1'b1;
            pend_q[0] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed table plus hand sequences for the writeback scheduler.
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        iss_valid;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        iss_has_rd;
    logic        iss_ready;
    logic [2:0]  wb_valid;
    logic [14:0] wb_rd;
    logic [95:0] wb_data;
    logic [2:0]  wb_ready;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic        err_unexp_wb;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        st;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        hrd;
        logic [2:0]  wv;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [2:0]  e_wbr;
        logic        e_issr;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_pend;
    } vec_t;

    vec_t tbl [15];

    rf_wb_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .iss_valid    (iss_valid),
        .iss_rs1      (iss_rs1),
        .iss_rs2      (iss_rs2),
        .iss_rd       (iss_rd),
        .iss_has_rd   (iss_has_rd),
        .iss_ready    (iss_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_ready     (wb_ready),
        .rf_we        (rf_we),
        .rf_rd_addr   (rf_rd_addr),
        .rf_wdata     (rf_wdata),
        .pending      (pending),
        .err_unexp_wb (err_unexp_wb)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input int st, input int iv, input int rs1, input int rs2,
        input int rd, input int hrd, input int wv,
        input int r0, input int r1, input int r2,
        input int ewbr, input int eir, input int ewe,
        input int ea, input int ed, input int ep
    );
        vec_t v;
        v.st     = st[0];
        v.iv     = iv[0];
        v.rs1    = 5'(rs1);
        v.rs2    = 5'(rs2);
        v.rd     = 5'(rd);
        v.hrd    = hrd[0];
        v.wv     = 3'(wv);
        v.r0     = 5'(r0);
        v.r1     = 5'(r1);
        v.r2     = 5'(r2);
        v.e_wbr  = 3'(ewbr);
        v.e_issr = eir[0];
        v.e_we   = ewe[0];
        v.e_addr = 5'(ea);
        v.e_data = 32'(ed);
        v.e_pend = 32'(ep);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_iss(input logic iv, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic hrd);
        iss_valid  = iv;
        iss_rs1    = rs1;
        iss_rs2    = rs2;
        iss_rd     = rd;
        iss_has_rd = hrd;
    endtask

    // Requester i supplies data (i+1)<<28 | rd.
    task automatic set_wb(input logic [2:0] v, input logic [4:0] r0,
                          input logic [4:0] r1, input logic [4:0] r2);
        wb_valid = v;
        wb_rd    = {r2, r1, r0};
        wb_data  = {32'h3000_0000 | {27'd0, r2},
                    32'h2000_0000 | {27'd0, r1},
                    32'h1000_0000 | {27'd0, r0}};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(1,0,0,0,0,0,'b000,0,0,0,'b000,1,0,0,0,0);
        tbl[1]  = mk(1,1,0,0,7,1,'b000,0,0,0,'b000,1,0,0,0,0);
        tbl[2]  = mk(1,1,7,0,8,1,'b010,0,7,0,'b010,0,0,0,0,'h80);
        tbl[3]  = mk(1,1,7,0,8,1,'b000,0,0,0,'b000,0,1,7,'h20000007,'h80);
        tbl[4]  = mk(1,1,7,0,8,1,'b000,0,0,0,'b000,1,0,7,'h20000007,0);
        tbl[5]  = mk(1,1,0,0,0,1,'b100,0,0,0,'b100,1,0,7,'h20000007,'h100);
        tbl[6]  = mk(1,0,0,0,0,0,'b000,0,0,0,'b000,1,0,0,'h30000000,'h100);
        tbl[7]  = mk(1,1,0,0,1,1,'b000,0,0,0,'b000,1,0,0,'h30000000,'h100);
        tbl[8]  = mk(1,1,0,0,2,1,'b000,0,0,0,'b000,1,0,0,'h30000000,'h102);
        tbl[9]  = mk(1,1,0,0,3,1,'b000,0,0,0,'b000,1,0,0,'h30000000,'h106);
        tbl[10] = mk(1,0,0,0,0,0,'b111,1,2,3,'b001,1,0,0,'h30000000,'h10E);
        tbl[11] = mk(1,1,0,0,10,1,'b110,1,2,3,'b010,1,1,1,'h10000001,'h10E);
        tbl[12] = mk(1,0,0,0,0,0,'b100,1,2,3,'b100,1,1,2,'h20000002,'h50C);
        tbl[13] = mk(1,0,0,0,0,0,'b111,0,0,0,'b001,1,1,3,'h30000003,'h508);
        tbl[14] = mk(1,0,0,0,0,0,'b000,0,0,0,'b000,1,0,0,'h10000000,'h500);

        reset = 1'b0;
        start = 1'b0;
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_wb(3'b000, 5'd0, 5'd0, 5'd0);
        #2;
        chk("reset rf_we", 32'(rf_we), 32'd0);
        chk("reset rf_rd_addr", 32'(rf_rd_addr), 32'd0);
        chk("reset rf_wdata", rf_wdata, 32'd0);
        chk("reset pending", pending, 32'd0);
        chk("reset err", 32'(err_unexp_wb), 32'd0);
        tick();
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            start = tbl[i].st;
            set_iss(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                    tbl[i].hrd);
            set_wb(tbl[i].wv, tbl[i].r0, tbl[i].r1, tbl[i].r2);
            @(negedge clk);
            chk($sformatf("row%0d wb_ready", i), 32'(wb_ready),
                32'(tbl[i].e_wbr));
            chk($sformatf("row%0d iss_ready", i), 32'(iss_ready),
                32'(tbl[i].e_issr));
            chk($sformatf("row%0d rf_we", i), 32'(rf_we),
                32'(tbl[i].e_we));
            chk($sformatf("row%0d rf_rd_addr", i), 32'(rf_rd_addr),
                32'(tbl[i].e_addr));
            chk($sformatf("row%0d rf_wdata", i), rf_wdata,
                tbl[i].e_data);
            chk($sformatf("row%0d pending", i), pending, tbl[i].e_pend);
            chk($sformatf("row%0d err", i), 32'(err_unexp_wb), 32'd0);
            tick();
        end

        // start gating: pending[9] set, then start dropped
        set_iss(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        set_wb(3'b000, 5'd0, 5'd0, 5'd0);
        tick();
        start = 1'b0;
        set_iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        set_wb(3'b001, 5'd9, 5'd0, 5'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("gate%0d wb_ready", c), 32'(wb_ready), 32'd0);
            chk($sformatf("gate%0d iss_ready", c), 32'(iss_ready), 32'd0);
            chk($sformatf("gate%0d pending", c), pending, 32'h700);
            chk($sformatf("gate%0d rf_we", c), 32'(rf_we), 32'd0);
            tick();
        end
        start = 1'b1;
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        chk("ungate wb_ready", 32'(wb_ready), 32'b001);
        tick();
        set_wb(3'b000, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        chk("ungate rf_we", 32'(rf_we), 32'd1);
        chk("ungate rf_rd_addr", 32'(rf_rd_addr), 32'd9);
        chk("ungate rf_wdata", rf_wdata, 32'h1000_0009);
        tick();
        @(negedge clk);
        chk("ungate clear", pending, 32'h500);
        chk("ungate err", 32'(err_unexp_wb), 32'd0);
        tick();

        // unexpected write to x12
        set_wb(3'b010, 5'd0, 5'd12, 5'd0);
        @(negedge clk);
        chk("unexp wb_ready", 32'(wb_ready), 32'b010);
        tick();
        set_wb(3'b000, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        chk("unexp rf_we", 32'(rf_we), 32'd1);
        chk("unexp rf_rd_addr", 32'(rf_rd_addr), 32'd12);
        chk("unexp err early", 32'(err_unexp_wb), 32'd0);
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("unexp sticky%0d", c), 32'(err_unexp_wb), 32'd1);
            tick();
        end

        // reset while an accepted write sits in the write stage
        set_wb(3'b001, 5'd5, 5'd0, 5'd0);
        wb_data[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst wb_ready", 32'(wb_ready), 32'b001);
        tick();
        set_wb(3'b000, 5'd0, 5'd0, 5'd0);
        chk("rst staged rf_we", 32'(rf_we), 32'd1);
        chk("rst staged data", rf_wdata, 32'hDEAD_BEEF);
        reset = 1'b0;
        #1;
        chk("rst rf_we", 32'(rf_we), 32'd0);
        chk("rst rf_wdata", rf_wdata, 32'd0);
        chk("rst pending", pending, 32'd0);
        chk("rst err", 32'(err_unexp_wb), 32'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post rst rf_we%0d", c), 32'(rf_we), 32'd0);
            chk($sformatf("post rst pend%0d", c), pending, 32'd0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
